// File: rtl/cpu_pkg.sv
package cpu_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4
  } load_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  // Encodings outside load_t are checked as full words.
  function automatic logic addr_aligned(input load_t t, input logic [1:0] off);
    case (t)
      LB, LBU: return 1'b1;
      LH, LHU: return ~off[0];
      default: return off == 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
module load_extend
  import cpu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  load_t       ltype,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[31:24];
    case (off)
      2'd0:    lane_b = rdata[31:24];
      2'd1:    lane_b = rdata[23:16];
      2'd2:    lane_b = rdata[15:8];
      default: lane_b = rdata[7:0];
    endcase
    lane_h = off[1] ? rdata[15:0] : rdata[31:16];
  end

  always_comb begin
    data = rdata;
    case (ltype)
      LB:      data = {{24{lane_b[7]}}, lane_b};
      LBU:     data = {24'h000000, lane_b};
      LH:      data = {{16{lane_h[15]}}, lane_h};
      LHU:     data = {16'h0000, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_align_ctrl.sv
module load_align_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        ReqValid,
  input  logic [2:0]  ReqType,
  input  logic [31:0] ReqAddr,
  input  logic        Flush,
  output logic        MemRead,
  output logic [31:0] MemAddr,
  input  logic        MemReady,
  input  logic [31:0] MemRData,
  output logic        Stall,
  output logic        RespValid,
  output logic [31:0] Result,
  output logic        AddrErr,
  output logic        BusErr
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t       state;
  lsu_state_t       state_nx;
  load_t            req_type;
  load_t            type_q;
  logic [1:0]       off_q;
  logic [31:0]      addr_q;
  logic [31:0]      result_q;
  logic [31:0]      ext_data;
  logic [CNT_W-1:0] cnt_q;
  logic             flushed_q;
  logic             buserr_q;
  logic             addrerr_q;
  logic             aligned;
  logic             take;
  logic             timeout;

  assign req_type = load_t'(ReqType);
  assign aligned  = addr_aligned(req_type, ReqAddr[1:0]);
  assign take     = ReqValid & ~Flush & aligned;
  assign timeout  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  load_extend u_extend (
    .rdata (MemRData),
    .off   (off_q),
    .ltype (type_q),
    .data  (ext_data)
  );

  always_ff @(posedge Clock) begin
    if (!nReset) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (take) state_nx = WAIT;
      WAIT:    if (MemReady || timeout) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    MemRead   = 1'b0;
    Stall     = 1'b0;
    RespValid = 1'b0;
    BusErr    = 1'b0;
    case (state)
      IDLE: Stall = take;
      WAIT: begin
        MemRead = 1'b1;
        Stall   = 1'b1;
      end
      RESP: begin
        RespValid = ~flushed_q & ~Flush;
        BusErr    = buserr_q & ~flushed_q & ~Flush;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      type_q    <= LB;
      off_q     <= '0;
      addr_q    <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      flushed_q <= 1'b0;
      buserr_q  <= 1'b0;
      addrerr_q <= 1'b0;
    end else begin
      addrerr_q <= (state == IDLE) & ReqValid & ~Flush & ~aligned;
      case (state)
        IDLE: begin
          buserr_q <= 1'b0;
          if (take) begin
            type_q <= req_type;
            off_q  <= ReqAddr[1:0];
            addr_q <= {ReqAddr[31:2], 2'b00};
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (Flush) flushed_q <= 1'b1;
          if (MemReady) begin
            result_q <= ext_data;
            buserr_q <= 1'b0;
          end else if (timeout) begin
            result_q <= '0;
            buserr_q <= 1'b1;
          end
        end
        RESP: begin
          flushed_q <= 1'b0;
          cnt_q     <= '0;
        end
        default: ;
      endcase
    end
  end

  assign MemAddr = addr_q;
  assign Result  = result_q;
  assign AddrErr = addrerr_q;

endmodule

// File: tb/tb_load_align_ctrl.sv
module tb_load_align_ctrl;
  import cpu_pkg::*;

  localparam int unsigned TMO = 8;

  logic        Clock    = 1'b0;
  logic        nReset   = 1'b0;
  logic        ReqValid = 1'b0;
  logic [2:0]  ReqType  = 3'd0;
  logic [31:0] ReqAddr  = '0;
  logic        Flush    = 1'b0;
  logic        MemReady = 1'b0;
  logic [31:0] MemRData = '0;
  logic        MemRead;
  logic [31:0] MemAddr;
  logic        Stall;
  logic        RespValid;
  logic [31:0] Result;
  logic        AddrErr;
  logic        BusErr;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  load_align_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .Clock     (Clock),
    .nReset    (nReset),
    .ReqValid  (ReqValid),
    .ReqType   (ReqType),
    .ReqAddr   (ReqAddr),
    .Flush     (Flush),
    .MemRead   (MemRead),
    .MemAddr   (MemAddr),
    .MemReady  (MemReady),
    .MemRData  (MemRData),
    .Stall     (Stall),
    .RespValid (RespValid),
    .Result    (Result),
    .AddrErr   (AddrErr),
    .BusErr    (BusErr)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic mdl_aligned(input logic [2:0] t, input logic [1:0] o);
    if (t == LB || t == LBU) return 1'b1;
    if (t == LH || t == LHU) return o[0] == 1'b0;
    return o == 2'b00;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [2:0] t, input logic [31:0] w, input logic [1:0] o);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * (3 - int'(o)))) & 32'h0000_00FF;
    h = (w >> (16 * (1 - int'(o[1])))) & 32'h0000_FFFF;
    if (t == LB)  return (b ^ 32'h80) - 32'h80;
    if (t == LBU) return b;
    if (t == LH)  return (h ^ 32'h8000) - 32'h8000;
    if (t == LHU) return h;
    return w;
  endfunction

  // Transaction-level model: one outstanding load, a wait count, a squash flag, a pending response.
  logic        m_busy = 1'b0;
  logic        m_resp = 1'b0;
  logic        m_squash = 1'b0;
  logic        m_err = 1'b0;
  logic        m_addrerr = 1'b0;
  logic [31:0] m_result = '0;
  logic [31:0] m_memaddr = '0;
  logic [2:0]  m_type = 3'd0;
  logic [1:0]  m_off = 2'd0;
  int          m_waited = 0;

  initial begin
    forever begin
      @(posedge Clock);
      if (!nReset) begin
        m_busy = 1'b0; m_resp = 1'b0; m_squash = 1'b0; m_err = 1'b0; m_addrerr = 1'b0;
        m_result = '0; m_memaddr = '0; m_waited = 0;
      end else begin
        m_addrerr = !m_busy && !m_resp && ReqValid && !Flush && !mdl_aligned(ReqType, ReqAddr[1:0]);
        if (m_resp) begin
          m_resp = 1'b0;
          m_squash = 1'b0;
        end else if (m_busy) begin
          m_waited++;
          if (Flush) m_squash = 1'b1;
          if (MemReady) begin
            m_result = mdl_load(m_type, MemRData, m_off);
            m_err = 1'b0; m_busy = 1'b0; m_resp = 1'b1;
          end else if (m_waited == int'(TMO)) begin
            m_result = '0;
            m_err = 1'b1; m_busy = 1'b0; m_resp = 1'b1;
          end
        end else if (ReqValid && !Flush && mdl_aligned(ReqType, ReqAddr[1:0])) begin
          m_busy = 1'b1;
          m_waited = 0;
          m_type = ReqType;
          m_off = ReqAddr[1:0];
          m_memaddr = ReqAddr & ~32'h3;
        end
      end
    end
  end

  initial begin
    logic e_stall;
    logic e_rv;
    forever begin
      @(negedge Clock);
      if (chk_en) begin
        e_stall = m_busy || (!m_resp && ReqValid && !Flush && mdl_aligned(ReqType, ReqAddr[1:0]));
        e_rv = m_resp && !m_squash && !Flush;
        check("MemRead", {31'd0, MemRead}, {31'd0, m_busy});
        check("Stall", {31'd0, Stall}, {31'd0, e_stall});
        check("RespValid", {31'd0, RespValid}, {31'd0, e_rv});
        check("BusErr", {31'd0, BusErr}, {31'd0, e_rv && m_err});
        check("AddrErr", {31'd0, AddrErr}, {31'd0, m_addrerr});
        check("Result", Result, m_result);
        check("MemAddr", MemAddr, m_memaddr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input logic rv, input logic [2:0] t, input logic [31:0] a, input logic fl,
                     input logic rdy, input logic [31:0] d, input logic rn = 1'b1);
    @(posedge Clock);
    #1;
    nReset = rn; ReqValid = rv; ReqType = t; ReqAddr = a; Flush = fl; MemReady = rdy; MemRData = d;
    #1;
  endtask

  int st;
  int rd;

  initial begin
    cyc(0, LB, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    cyc(0, LB, 0, 0, 0, 0, 0);
    check("rst_memread", {31'd0, MemRead}, 0);
    check("rst_stall", {31'd0, Stall}, 0);
    check("rst_respvalid", {31'd0, RespValid}, 0);
    check("rst_result", Result, 0);
    check("rst_memaddr", MemAddr, 0);
    check("rst_errs", {30'd0, AddrErr, BusErr}, 0);

    // LB 0x103, ready in first WAIT cycle
    cyc(1, LB, 32'h103, 0, 0, 0);
    check("t1_stall_c0", {31'd0, Stall}, 1);
    check("t1_memread_c0", {31'd0, MemRead}, 0);
    cyc(1, LB, 32'h103, 0, 1, 32'h1234_56F0);
    check("t1_memread_c1", {31'd0, MemRead}, 1);
    check("t1_memaddr", MemAddr, 32'h100);
    cyc(1, LB, 32'h103, 0, 0, 0);
    check("t1_respvalid_c2", {31'd0, RespValid}, 1);
    check("t1_result", Result, 32'hFFFF_FFF0);
    check("t1_stall_c2", {31'd0, Stall}, 0);
    cyc(0, LB, 0, 0, 0, 0);
    check("t1_result_hold", Result, 32'hFFFF_FFF0);

    // LHU 0x102, ready after 4 WAIT cycles
    st = 0;
    cyc(1, LHU, 32'h102, 0, 0, 0); if (Stall) st++;
    for (int unsigned i = 0; i < 3; i++) begin
      cyc(1, LHU, 32'h102, 0, 0, 0); if (Stall) st++;
    end
    cyc(1, LHU, 32'h102, 0, 1, 32'h1234_ABCD); if (Stall) st++;
    cyc(1, LHU, 32'h102, 0, 0, 0); if (Stall) st++;
    check("t2_respvalid", {31'd0, RespValid}, 1);
    check("t2_result", Result, 32'h0000_ABCD);
    check("t2_stall_cycles", st, 5);
    cyc(0, LB, 0, 0, 0, 0);

    // LW 0x201 misaligned
    cyc(1, LW, 32'h201, 0, 0, 0);
    check("t3_stall", {31'd0, Stall}, 0);
    check("t3_memread_c0", {31'd0, MemRead}, 0);
    cyc(0, LB, 0, 0, 0, 0);
    check("t3_addrerr", {31'd0, AddrErr}, 1);
    check("t3_respvalid", {31'd0, RespValid}, 0);
    check("t3_memread_c1", {31'd0, MemRead}, 0);
    cyc(0, LB, 0, 0, 0, 0);
    check("t3_addrerr_pulse", {31'd0, AddrErr}, 0);

    // LH 0x0 timeout
    rd = 0;
    cyc(1, LH, 32'h0, 0, 0, 0); if (MemRead) rd++;
    for (int unsigned i = 0; i < TMO; i++) begin
      cyc(1, LH, 32'h0, 0, 0, 0); if (MemRead) rd++;
    end
    cyc(1, LH, 32'h0, 0, 0, 0); if (MemRead) rd++;
    check("t4_memread_cycles", rd, TMO);
    check("t4_buserr", {31'd0, BusErr}, 1);
    check("t4_respvalid", {31'd0, RespValid}, 1);
    check("t4_result", Result, 32'h0);
    cyc(0, LB, 0, 0, 0, 0);
    check("t4_buserr_pulse", {31'd0, BusErr}, 0);

    // LB flushed in WAIT, then a normal LBU
    cyc(1, LB, 32'h101, 0, 0, 0);
    cyc(1, LB, 32'h101, 0, 0, 0);
    cyc(1, LB, 32'h101, 1, 0, 0);
    check("t5_stall_flush", {31'd0, Stall}, 1);
    cyc(0, LB, 0, 0, 1, 32'hAABB_CCDD);
    cyc(0, LB, 0, 0, 0, 0);
    check("t5_no_resp", {31'd0, RespValid}, 0);
    cyc(1, LBU, 32'h101, 0, 0, 0);
    check("t5_next_accept", {31'd0, Stall}, 1);
    cyc(1, LBU, 32'h101, 0, 1, 32'h00AB_0000);
    cyc(1, LBU, 32'h101, 0, 0, 0);
    check("t5_respvalid", {31'd0, RespValid}, 1);
    check("t5_result", Result, 32'h0000_00AB);
    cyc(0, LB, 0, 0, 0, 0);

    // Reset in WAIT, late MemReady
    cyc(1, LW, 32'h300, 0, 0, 0);
    cyc(1, LW, 32'h300, 0, 0, 0);
    check("t6_memaddr", MemAddr, 32'h300);
    cyc(1, LW, 32'h300, 0, 0, 0, 0);
    cyc(0, LW, 0, 0, 1, 32'h5555_5555);
    check("t6_memread", {31'd0, MemRead}, 0);
    check("t6_memaddr_rst", MemAddr, 0);
    check("t6_result_rst", Result, 0);
    cyc(0, LB, 0, 0, 0, 0);
    check("t6_no_resp", {31'd0, RespValid}, 0);

    // LH sign, LW with Flush in RESP, LW ready on last WAIT cycle
    cyc(1, LH, 32'h206, 0, 0, 0);
    cyc(1, LH, 32'h206, 0, 1, 32'h1234_8765);
    cyc(1, LH, 32'h206, 0, 0, 0);
    check("t7_lh_result", Result, 32'hFFFF_8765);
    cyc(1, LW, 32'h404, 0, 0, 0);
    cyc(1, LW, 32'h404, 0, 1, 32'hDEAD_BEEF);
    cyc(1, LW, 32'h404, 1, 0, 0);
    check("t7_resp_flushed", {31'd0, RespValid}, 0);
    check("t7_lw_result", Result, 32'hDEAD_BEEF);
    cyc(1, LW, 32'h408, 0, 0, 0);
    for (int unsigned i = 0; i < TMO - 1; i++) cyc(1, LW, 32'h408, 0, 0, 0);
    cyc(1, LW, 32'h408, 0, 1, 32'h0BAD_F00D);
    cyc(1, LW, 32'h408, 0, 0, 0);
    check("t7_last_ready_rv", {31'd0, RespValid}, 1);
    check("t7_last_ready_be", {31'd0, BusErr}, 0);
    check("t7_last_ready_res", Result, 32'h0BAD_F00D);
    cyc(0, LB, 0, 0, 0, 0);
    cyc(0, LB, 0, 0, 0, 0);

    @(posedge Clock);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
